// File: rtl/label_ram_arbiter.sv
// Label RAM arbiter: video reads have absolute priority on the single-port RAM;
// writers are granted round-robin into a one-entry buffer that commits on video-idle cycles.
module label_ram_arbiter #(
  parameter int ADDR_W   = 8,
  parameter int DATA_W   = 8,
  parameter int NWR      = 2,
  parameter int MAX_WAIT = 1023
) (
  input  logic                  px_clk,
  input  logic                  rst_n,
  input  logic                  vid_req,
  input  logic [ADDR_W-1:0]     vid_addr,
  output logic                  vid_valid,
  output logic [DATA_W-1:0]     vid_data,
  input  logic [NWR-1:0]        wr_valid,
  input  logic [NWR*ADDR_W-1:0] wr_addr,
  input  logic [NWR*DATA_W-1:0] wr_data,
  output logic [NWR-1:0]        wr_ready,
  output logic [ADDR_W-1:0]     ram_addr,
  output logic                  ram_we,
  output logic [DATA_W-1:0]     ram_din,
  input  logic [DATA_W-1:0]     ram_dout,
  output logic [15:0]           commit_cnt,
  output logic                  stall_err
);

  localparam int PW = (NWR > 1) ? $clog2(NWR) : 1;
  localparam int WW = $clog2(MAX_WAIT + 1);

  logic [NWR-1:0][ADDR_W-1:0] wa;
  logic [NWR-1:0][DATA_W-1:0] wd;
  assign wa = wr_addr;
  assign wd = wr_data;

  logic              vid_valid_q, vid_valid_d;
  logic              pend_vld_q, pend_vld_d;
  logic [ADDR_W-1:0] pend_addr_q, pend_addr_d;
  logic [DATA_W-1:0] pend_data_q, pend_data_d;
  logic [PW-1:0]     rr_ptr_q, rr_ptr_d;
  logic [WW-1:0]     wait_cnt_q, wait_cnt_d;
  logic [15:0]       commit_cnt_q, commit_cnt_d;
  logic              stall_err_q, stall_err_d;

  logic          gnt_vld;
  logic [PW-1:0] gnt_idx;
  logic          commit;
  int            idx;

  // Round-robin search starting at rr_ptr; only offered while the buffer is empty.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    idx     = 0;
    if (!pend_vld_q) begin
      for (int k = 0; k < NWR; k++) begin
        idx = (int'(rr_ptr_q) + k) % NWR;
        if (!gnt_vld && wr_valid[idx]) begin
          gnt_vld = 1'b1;
          gnt_idx = PW'(idx);
        end
      end
    end
  end

  assign wr_ready = gnt_vld ? (NWR'(1) << gnt_idx) : '0;
  assign commit   = pend_vld_q & ~vid_req;

  always_comb begin
    ram_addr = '0;
    ram_we   = 1'b0;
    ram_din  = '0;
    if (vid_req) begin
      ram_addr = vid_addr;
    end else if (pend_vld_q) begin
      ram_addr = pend_addr_q;
      ram_we   = 1'b1;
      ram_din  = pend_data_q;
    end
  end

  always_comb begin
    vid_valid_d  = vid_req;
    pend_vld_d   = pend_vld_q;
    pend_addr_d  = pend_addr_q;
    pend_data_d  = pend_data_q;
    rr_ptr_d     = rr_ptr_q;
    commit_cnt_d = commit_cnt_q;
    wait_cnt_d   = '0;
    if (commit) begin
      pend_vld_d   = 1'b0;
      commit_cnt_d = commit_cnt_q + 16'd1;
    end
    if (gnt_vld) begin
      pend_vld_d  = 1'b1;
      pend_addr_d = wa[gnt_idx];
      pend_data_d = wd[gnt_idx];
      rr_ptr_d    = PW'((int'(gnt_idx) + 1) % NWR);
    end
    // Only consecutive blocked cycles count; any non-blocked cycle restarts the run.
    if (pend_vld_q && vid_req)
      wait_cnt_d = (wait_cnt_q == WW'(MAX_WAIT)) ? wait_cnt_q : wait_cnt_q + WW'(1);
    stall_err_d = stall_err_q | (wait_cnt_d == WW'(MAX_WAIT));
  end

  always_ff @(posedge px_clk or negedge rst_n) begin
    if (!rst_n) begin
      vid_valid_q  <= 1'b0;
      pend_vld_q   <= 1'b0;
      pend_addr_q  <= '0;
      pend_data_q  <= '0;
      rr_ptr_q     <= '0;
      wait_cnt_q   <= '0;
      commit_cnt_q <= '0;
      stall_err_q  <= 1'b0;
    end else begin
      vid_valid_q  <= vid_valid_d;
      pend_vld_q   <= pend_vld_d;
      pend_addr_q  <= pend_addr_d;
      pend_data_q  <= pend_data_d;
      rr_ptr_q     <= rr_ptr_d;
      wait_cnt_q   <= wait_cnt_d;
      commit_cnt_q <= commit_cnt_d;
      stall_err_q  <= stall_err_d;
    end
  end

  assign vid_valid  = vid_valid_q;
  assign vid_data   = ram_dout;
  assign commit_cnt = commit_cnt_q;
  assign stall_err  = stall_err_q;

endmodule

// File: tb/tb_label_ram_arbiter.sv
// Directed bench for label_ram_arbiter with a behavioural single-port RAM (1-cycle read).
module tb_label_ram_arbiter;

  logic        px_clk = 1'b0;
  logic        rst_n;
  logic        vid_req;
  logic [7:0]  vid_addr;
  logic        vid_valid;
  logic [7:0]  vid_data;
  logic [1:0]  wr_valid;
  logic [15:0] wr_addr;
  logic [15:0] wr_data;
  logic [1:0]  wr_ready;
  logic [7:0]  ram_addr;
  logic        ram_we;
  logic [7:0]  ram_din;
  logic [7:0]  ram_dout;
  logic [15:0] commit_cnt;
  logic        stall_err;

  int nvec = 0;
  int nerr = 0;

  logic [7:0] mem [256];

  always #5 px_clk = ~px_clk;

  always @(posedge px_clk) begin
    if (ram_we) mem[ram_addr] <= ram_din;
    ram_dout <= mem[ram_addr];
  end

  label_ram_arbiter #(.ADDR_W(8), .DATA_W(8), .NWR(2), .MAX_WAIT(4)) dut (
    .px_clk(px_clk), .rst_n(rst_n),
    .vid_req(vid_req), .vid_addr(vid_addr), .vid_valid(vid_valid), .vid_data(vid_data),
    .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ready(wr_ready),
    .ram_addr(ram_addr), .ram_we(ram_we), .ram_din(ram_din), .ram_dout(ram_dout),
    .commit_cnt(commit_cnt), .stall_err(stall_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    if (obs !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; checks happen on the falling edge.
  task automatic tick();
    @(posedge px_clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    vid_req = 1'b0; wr_valid = 2'b00;
    tick(); tick();
    rst_n = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    mem[8'h1C] = 8'h41;
    vid_addr = 8'h00; wr_addr = 16'h0; wr_data = 16'h0; ram_dout = 8'h00;
    rst_n = 1'b0; vid_req = 1'b0; wr_valid = 2'b00;
    #1; tick(); tick();
    @(negedge px_clk);
    chk("rst_vid_valid", 32'(vid_valid), 32'd0);
    chk("rst_ram_we", 32'(ram_we), 32'd0);
    chk("rst_commit_cnt", 32'(commit_cnt), 32'd0);
    chk("rst_stall_err", 32'(stall_err), 32'd0);
    tick();
    rst_n = 1'b1;

    // Video read of a preloaded location.
    vid_req = 1'b1; vid_addr = 8'h1C;
    @(negedge px_clk);
    chk("vid_ram_addr", 32'(ram_addr), 32'h1C);
    chk("vid_ram_we0", 32'(ram_we), 32'd0);
    tick();
    vid_req = 1'b0;
    @(negedge px_clk);
    chk("vid_valid", 32'(vid_valid), 32'd1);
    chk("vid_data", 32'(vid_data), 32'h41);
    chk("vid_ram_we1", 32'(ram_we), 32'd0);
    tick();

    // Idle write from writer 0.
    wr_valid = 2'b01; wr_addr = 16'h0030; wr_data = 16'h005A;
    @(negedge px_clk);
    chk("iw_ready", 32'(wr_ready), 32'b01);
    tick();
    wr_valid = 2'b00;
    @(negedge px_clk);
    chk("iw_we", 32'(ram_we), 32'd1);
    chk("iw_addr", 32'(ram_addr), 32'h30);
    chk("iw_din", 32'(ram_din), 32'h5A);
    chk("iw_ready_pend", 32'(wr_ready), 32'b00);
    tick();
    @(negedge px_clk);
    chk("iw_cnt", 32'(commit_cnt), 32'd1);
    chk("iw_we_after", 32'(ram_we), 32'd0);
    chk("iw_mem", 32'(mem[8'h30]), 32'h5A);

    // Round-robin with both writers held valid, starting from a fresh pointer.
    do_reset();
    wr_valid = 2'b11; wr_addr = 16'h1110; wr_data = 16'hB1A0;
    for (int c = 0; c < 8; c++) begin
      @(negedge px_clk);
      if (c % 2 == 0) begin
        chk("rr_ready", 32'(wr_ready), ((c / 2) % 2 == 0) ? 32'b01 : 32'b10);
        chk("rr_we_idle", 32'(ram_we), 32'd0);
      end else begin
        chk("rr_ready_pend", 32'(wr_ready), 32'b00);
        chk("rr_we", 32'(ram_we), 32'd1);
        chk("rr_addr", 32'(ram_addr), ((c / 2) % 2 == 0) ? 32'h10 : 32'h11);
        chk("rr_din", 32'(ram_din), ((c / 2) % 2 == 0) ? 32'hA0 : 32'hB1);
      end
      tick();
    end
    wr_valid = 2'b00;
    @(negedge px_clk);
    chk("rr_cnt", 32'(commit_cnt), 32'd4);

    // Video blocks a pending write for 5 cycles.
    vid_req = 1'b1; vid_addr = 8'h02;
    wr_valid = 2'b01; wr_addr = 16'h0055; wr_data = 16'h0066;
    tick();
    wr_valid = 2'b00;
    for (int c = 0; c < 5; c++) begin
      @(negedge px_clk);
      chk("blk_we", 32'(ram_we), 32'd0);
      chk("blk_addr", 32'(ram_addr), 32'h02);
      tick();
    end
    vid_req = 1'b0;
    @(negedge px_clk);
    chk("blk_wait_sat", 32'(dut.wait_cnt_q), 32'd4);
    chk("blk_commit_we", 32'(ram_we), 32'd1);
    chk("blk_commit_addr", 32'(ram_addr), 32'h55);
    chk("blk_commit_din", 32'(ram_din), 32'h66);
    tick();
    @(negedge px_clk);
    chk("blk_wait_clr", 32'(dut.wait_cnt_q), 32'd0);
    chk("blk_cnt", 32'(commit_cnt), 32'd5);

    // Starvation: stall_err rises after the 4th blocked cycle and is sticky.
    do_reset();
    vid_req = 1'b1; vid_addr = 8'h03;
    wr_valid = 2'b01; wr_addr = 16'h0044; wr_data = 16'h0099;
    tick();
    wr_valid = 2'b00;
    for (int c = 1; c <= 6; c++) begin
      tick();
      @(negedge px_clk);
      chk("stv_err", 32'(stall_err), (c >= 4) ? 32'd1 : 32'd0);
    end
    tick();
    vid_req = 1'b0;
    @(negedge px_clk);
    chk("stv_commit_we", 32'(ram_we), 32'd1);
    tick();
    @(negedge px_clk);
    chk("stv_err_sticky", 32'(stall_err), 32'd1);
    chk("stv_cnt", 32'(commit_cnt), 32'd1);

    // Reset while a write is pending: nothing reaches the RAM.
    tick();
    vid_req = 1'b1; vid_addr = 8'h04;
    wr_valid = 2'b10; wr_addr = 16'h7700; wr_data = 16'h8800;
    tick();
    wr_valid = 2'b00;
    @(negedge px_clk);
    chk("mr_pend", 32'(dut.pend_vld_q), 32'd1);
    rst_n = 1'b0; vid_req = 1'b0;
    #1;
    chk("mr_pend_rst", 32'(dut.pend_vld_q), 32'd0);
    for (int c = 0; c < 2; c++) begin
      @(negedge px_clk);
      chk("mr_we_rst", 32'(ram_we), 32'd0);
    end
    tick();
    rst_n = 1'b1;
    @(negedge px_clk);
    chk("mr_we_post", 32'(ram_we), 32'd0);
    chk("mr_cnt", 32'(commit_cnt), 32'd0);
    chk("mr_rr_ptr", 32'(dut.rr_ptr_q), 32'd0);
    chk("mr_err", 32'(stall_err), 32'd0);
    chk("mr_mem", 32'(mem[8'h77]), 32'h00);
    tick();
    wr_valid = 2'b11; wr_addr = 16'h0101; wr_data = 16'h0202;
    @(negedge px_clk);
    chk("mr_first_grant", 32'(wr_ready), 32'b01);
    tick();
    wr_valid = 2'b00;

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running, want finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/label_ram_arbiter.md
LABEL_RAM_ARBITER -- requirements
Module: label_ram_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 8: label RAM address width.
REQ-002 SHALL have parameter DATA_W, default 8: label RAM data width.
REQ-003 SHALL have parameter NWR, default 2: number of writer requesters (2..4).
REQ-004 SHALL have parameter MAX_WAIT, default 1023: blocked-commit cycles before stall error.
REQ-005 SHALL have port px_clk, input, 1: the single clock; all state updates on its rising edge.
REQ-006 SHALL have port rst_n, input, 1: reset, asynchronous, active-low.
REQ-007 SHALL have port vid_req, input, 1: video pipeline requests a character read this cycle.
REQ-008 SHALL have port vid_addr, input, ADDR_W: video read address.
REQ-009 SHALL have port vid_valid, output, 1: vid_data holds the read requested the previous cycle.
REQ-010 SHALL have port vid_data, output, DATA_W: read data to the video pipeline.
REQ-011 SHALL have port wr_valid, input, NWR: per-writer write request.
REQ-012 SHALL have port wr_addr, input, NWR*ADDR_W: packed write addresses, writer i at slice i.
REQ-013 SHALL have port wr_data, input, NWR*DATA_W: packed write data, writer i at slice i.
REQ-014 SHALL have port wr_ready, output, NWR: per-writer accept; transfer when wr_valid[i] and wr_ready[i] are high at the same edge.
REQ-015 SHALL have port ram_addr, output, ADDR_W: address to the single-port label RAM.
REQ-016 SHALL have port ram_we, output, 1: RAM write enable.
REQ-017 SHALL have port ram_din, output, DATA_W: RAM write data.
REQ-018 SHALL have port ram_dout, input, DATA_W: RAM synchronous read data, one-cycle latency.
REQ-019 SHALL have port commit_cnt, output, 16: count of RAM writes performed.
REQ-020 SHALL have port stall_err, output, 1: sticky flag, write starved by video.

Function
REQ-021 SHALL give video absolute priority: with vid_req=1, ram_addr=vid_addr and ram_we=0 in the same cycle (combinational).
REQ-022 SHALL register vid_valid as vid_req delayed by one cycle; vid_data SHALL equal ram_dout combinationally.
REQ-023 SHALL hold one pending-write buffer (pend_vld, pend_addr, pend_data).
REQ-024 SHALL assert wr_ready for at most one writer per cycle, and only while pend_vld=0.
REQ-025 SHALL select that writer round-robin: first i with wr_valid[i]=1, searching from pointer rr_ptr upward modulo NWR; wr_ready may depend combinationally on wr_valid.
REQ-026 SHALL, on transfer from writer g, set pend_vld=1, latch that writer's address/data, and set rr_ptr=(g+1) mod NWR.
REQ-027 SHALL commit when pend_vld=1 and vid_req=0: ram_we=1, ram_addr=pend_addr, ram_din=pend_data; pend_vld clears at that edge.
REQ-028 SHALL NOT accept a new write in the commit cycle; maximum write throughput is one write per two cycles.
REQ-029 SHALL drive ram_addr=0, ram_we=0 and ram_din=0 when neither video nor commit is active.
REQ-030 SHALL increment commit_cnt by 1 per commit, wrapping from 16'hFFFF to 0.
REQ-031 SHALL count consecutive cycles with pend_vld=1 and vid_req=1 in wait_cnt, which saturates at MAX_WAIT and clears on commit.
REQ-032 SHALL set stall_err when wait_cnt reaches MAX_WAIT; stall_err stays set until reset.

Reset
REQ-033 SHALL, while rst_n=0, force vid_valid=0, pend_vld=0, rr_ptr=0, wait_cnt=0, commit_cnt=0 and stall_err=0.
REQ-034 SHALL discard any pending uncommitted write on reset; ram_we=0 throughout reset.

Verification
REQ-035 SHALL verify video read: vid_req=1, vid_addr=8'h1C, RAM holds 8'h41 -> next cycle vid_valid=1, vid_data=8'h41, ram_we=0 throughout.
REQ-036 SHALL verify idle write: vid_req=0, wr_valid=2'b01, addr 8'h30, data 8'h5A -> wr_ready[0]=1 at edge 0, ram_we=1 with addr 8'h30, data 8'h5A in cycle 1, commit_cnt=1.
REQ-037 SHALL verify round-robin: both writers held valid, vid_req=0 -> grants alternate 0,1,0,1; 4 commits within 8 cycles.
REQ-038 SHALL verify video blocking: pending write with vid_req=1 for 5 cycles -> ram_we=0 for those 5 cycles, commit in the first cycle vid_req=0, wait_cnt cleared.
REQ-039 SHALL verify starvation: MAX_WAIT=4, pending write, vid_req=1 for 6 cycles -> stall_err=1 after the 4th blocked cycle and still 1 after commit.
REQ-040 SHALL verify reset mid-operation: rst_n low while pend_vld=1 -> no write occurs, and after release commit_cnt=0, rr_ptr=0, wr_ready[0] granted first.
